// File: rtl/cmp_pkg.sv
// Shared sizing for the SIMD comparator: default widths, derived lane counts,
// plus mode saturation and lane-count helpers.
package cmp_pkg;

  localparam int CMP_DATA_W   = 64;
  localparam int CMP_CHUNK_W  = 8;
  localparam int CMP_TAG_W    = 4;
  localparam int CMP_NCHUNK   = CMP_DATA_W / CMP_CHUNK_W;
  localparam int CMP_MAX_MODE = $clog2(CMP_NCHUNK);
  localparam int CMP_MODE_W   = $clog2(CMP_MAX_MODE + 1);

  // Out-of-range modes collapse to the single full-width lane.
  function automatic int sat_mode(input int mode, input int max_mode);
    return (mode > max_mode) ? max_mode : mode;
  endfunction

  function automatic int lane_count(input int mode, input int nchunk);
    return nchunk >> mode;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Purpose: equality and unsigned less-than for one CHUNK_W slice of the operands.
// Latency: combinational. Backpressure: none, pure logic.
module cmp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         ult
);

  assign eq  = (a == b);
  assign ult = (a < b);

endmodule

// File: rtl/simd_compare_pipe.sv
// Purpose: lane-configurable SIMD eq/slt/ult comparator with tag passthrough.
// Latency: 2 cycles, 1 beat/cycle. Backpressure: out_ready stalls S2 then S1; holds 2 beats.
module simd_compare_pipe
  import cmp_pkg::*;
#(
  parameter int  DATA_W   = CMP_DATA_W,
  parameter int  CHUNK_W  = CMP_CHUNK_W,
  parameter int  TAG_W    = CMP_TAG_W,
  localparam int NCHUNK   = DATA_W / CHUNK_W,
  localparam int MAX_MODE = $clog2(NCHUNK),
  localparam int MODE_W   = $clog2(MAX_MODE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCHUNK-1:0] out_eq,
  output logic [NCHUNK-1:0] out_slt,
  output logic [NCHUNK-1:0] out_ult,
  output logic [TAG_W-1:0]  out_tag
);

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Per-chunk compare on the raw operands.
  logic [NCHUNK-1:0] c_eq;
  logic [NCHUNK-1:0] c_ult;
  logic [NCHUNK-1:0] c_amsb;
  logic [NCHUNK-1:0] c_bmsb;

  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    cmp_chunk #(.W(CHUNK_W)) u_chunk (
      .a   (in_a[c*CHUNK_W +: CHUNK_W]),
      .b   (in_b[c*CHUNK_W +: CHUNK_W]),
      .eq  (c_eq[c]),
      .ult (c_ult[c])
    );
    assign c_amsb[c] = in_a[c*CHUNK_W + CHUNK_W - 1];
    assign c_bmsb[c] = in_b[c*CHUNK_W + CHUNK_W - 1];
  end

  logic [NCHUNK-1:0] s1_eq;
  logic [NCHUNK-1:0] s1_ult;
  logic [NCHUNK-1:0] s1_amsb;
  logic [NCHUNK-1:0] s1_bmsb;
  logic [MODE_W-1:0] s1_mode;
  logic [TAG_W-1:0]  s1_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eq    <= '0;
      s1_ult   <= '0;
      s1_amsb  <= '0;
      s1_bmsb  <= '0;
      s1_mode  <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_eq   <= c_eq;
        s1_ult  <= c_ult;
        s1_amsb <= c_amsb;
        s1_bmsb <= c_bmsb;
        s1_mode <= MODE_W'(sat_mode(int'(in_mode), MAX_MODE));
        s1_tag  <= in_tag;
      end
    end
  end

  // Every lane width is evaluated in parallel; s1_mode picks one result set.
  logic [MAX_MODE:0][NCHUNK-1:0] mode_eq;
  logic [MAX_MODE:0][NCHUNK-1:0] mode_ult;
  logic [MAX_MODE:0][NCHUNK-1:0] mode_slt;

  for (genvar m = 0; m <= MAX_MODE; m++) begin : g_mode
    localparam int LW = 1 << m;
    localparam int NL = lane_count(m, NCHUNK);

    logic [NCHUNK-1:0] l_eq;
    logic [NCHUNK-1:0] l_ult;
    logic [NCHUNK-1:0] l_slt;

    // Chunks walked LSB to MSB so the highest unequal chunk decides ult.
    always_comb begin
      l_eq  = '0;
      l_ult = '0;
      l_slt = '0;
      for (int i = 0; i < NL; i++) begin
        l_eq[i] = 1'b1;
        for (int j = 0; j < LW; j++) begin
          if (!s1_eq[i*LW + j]) l_ult[i] = s1_ult[i*LW + j];
          l_eq[i] = l_eq[i] & s1_eq[i*LW + j];
        end
        l_slt[i] = (s1_amsb[i*LW + LW - 1] & ~s1_bmsb[i*LW + LW - 1]) |
                   ((s1_amsb[i*LW + LW - 1] == s1_bmsb[i*LW + LW - 1]) & l_ult[i]);
      end
    end

    assign mode_eq[m]  = l_eq;
    assign mode_ult[m] = l_ult;
    assign mode_slt[m] = l_slt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_eq   <= '0;
      out_slt  <= '0;
      out_ult  <= '0;
      out_tag  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_eq  <= mode_eq[s1_mode];
        out_slt <= mode_slt[s1_mode];
        out_ult <= mode_ult[s1_mode];
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_simd_compare_pipe.sv
// Directed bench for simd_compare_pipe: lane splits, stall/capacity, full rate, reset flush.
module tb_simd_compare_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_eq;
  logic [7:0]  out_slt;
  logic [7:0]  out_ult;
  logic [3:0]  out_tag;

  int checks;
  int failures;

  simd_compare_pipe #(.DATA_W(64), .CHUNK_W(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_slt   (out_slt),
    .out_ult   (out_ult),
    .out_tag   (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Offers one beat with out_ready=1 and waits for its result; lat=-1 on timeout.
  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [1:0] mode,
                         input logic [3:0] tag, output logic [7:0] eq, output logic [7:0] slt,
                         output logic [7:0] ult, output logic [3:0] tg, output int lat);
    int w;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = a; in_b = b; in_mode = mode; in_tag = tag; in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    eq = out_eq; slt = out_slt; ult = out_ult; tg = out_tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_eq !== 8'h00) begin failures++; $display("FAIL reset_out_eq got=%h exp=00", out_eq); end
    checks++; if (out_slt !== 8'h00 || out_ult !== 8'h00) begin failures++; $display("FAIL reset_lt_masks got slt=%h ult=%h exp=00", out_slt, out_ult); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
  endtask

  task automatic test_full_width();
    logic [7:0] eq, slt, ult; logic [3:0] tg; int lat;
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd3, 4'h3, eq, slt, ult, tg, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL full_latency got=%0d exp=2", lat); end
    checks++; if (eq !== 8'h00) begin failures++; $display("FAIL full_eq got=%h exp=00", eq); end
    checks++; if (slt !== 8'h01) begin failures++; $display("FAIL full_slt got=%h exp=01", slt); end
    checks++; if (ult !== 8'h00) begin failures++; $display("FAIL full_ult got=%h exp=00", ult); end
    checks++; if (tg !== 4'h3) begin failures++; $display("FAIL full_tag got=%h exp=3", tg); end
  endtask

  task automatic test_half_width();
    logic [7:0] eq, slt, ult; logic [3:0] tg; int lat;
    run_one(64'h0000_0005_8000_0000, 64'h0000_0005_0000_0001, 2'd2, 4'h6, eq, slt, ult, tg, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL half_latency got=%0d exp=2", lat); end
    checks++; if (eq !== 8'h02) begin failures++; $display("FAIL half_eq got=%h exp=02", eq); end
    checks++; if (slt !== 8'h01) begin failures++; $display("FAIL half_slt got=%h exp=01", slt); end
    checks++; if (ult !== 8'h00) begin failures++; $display("FAIL half_ult got=%h exp=00", ult); end
  endtask

  task automatic test_byte_lanes();
    logic [7:0] eq, slt, ult; logic [3:0] tg; int lat;
    // Byte 6 is 8'hFF vs 8'h01: -1 < 1 signed, so slt bit 6 is set along with bits 4 and 0.
    run_one(64'h01FF_0380_0506_0708, 64'h0101_0300_0506_0709, 2'd0, 4'hA, eq, slt, ult, tg, lat);
    checks++; if (eq !== 8'hAE) begin failures++; $display("FAIL byte_eq got=%h exp=ae", eq); end
    checks++; if (slt !== 8'h51) begin failures++; $display("FAIL byte_slt got=%h exp=51", slt); end
    checks++; if (ult !== 8'h01) begin failures++; $display("FAIL byte_ult got=%h exp=01", ult); end
    checks++; if (tg !== 4'hA) begin failures++; $display("FAIL byte_tag got=%h exp=a", tg); end
  endtask

  task automatic test_stall();
    int acc, got;
    logic hs_in, hs_out;
    logic [3:0] tags [3];
    acc = 0; got = 0;
    tags[0] = '0; tags[1] = '0; tags[2] = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 3);
      in_a = 64'(acc + 1); in_b = 64'(acc + 1); in_mode = 2'd3; in_tag = 4'(acc + 1);
      #1;
      hs_in = in_valid && in_ready;
      @(posedge clk);
      if (hs_in) acc++;
      @(negedge clk);
    end
    #1;
    checks++; if (acc != 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 3);
      in_a = 64'(acc + 1); in_b = 64'(acc + 1); in_mode = 2'd3; in_tag = 4'(acc + 1);
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        if (got < 3) tags[got] = out_tag;
        got++;
      end
      @(posedge clk);
      if (hs_in) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL stall_result_count got=%0d exp=3", got); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tags[k] !== 4'(k + 1)) begin failures++; $display("FAIL stall_tag_order idx=%0d got=%h exp=%h", k, tags[k], 4'(k + 1)); end
    end
  endtask

  task automatic test_back_to_back();
    int modes [5];
    logic [7:0] exp_eq [5], exp_slt [5], exp_ult [5];
    logic [7:0] got_eq [5], got_slt [5], got_ult [5];
    logic [3:0] got_tag [5];
    int sent, got, first, last;
    logic hs_in;
    modes   = '{0, 1, 2, 3, 7};
    exp_eq  = '{8'hAE, 8'h02, 8'h00, 8'h00, 8'h00};
    exp_slt = '{8'h51, 8'h01, 8'h01, 8'h00, 8'h00};
    exp_ult = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    for (int k = 0; k < 5; k++) begin got_eq[k] = 'x; got_slt[k] = 'x; got_ult[k] = 'x; got_tag[k] = 'x; end
    sent = 0; got = 0; first = -1; last = -1;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 64'h01FF_0380_0506_0708; in_b = 64'h0101_0300_0506_0709;
    for (int c = 0; c < 15; c++) begin
      in_valid = (sent < 5);
      in_mode  = 2'(modes[sent < 5 ? sent : 4]);
      in_tag   = 4'(sent + 4);
      #1;
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", sent, in_ready); end
      end
      hs_in = in_valid && in_ready;
      if (out_valid) begin
        if (got < 5) begin
          got_eq[got] = out_eq; got_slt[got] = out_slt; got_ult[got] = out_ult; got_tag[got] = out_tag;
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk);
      if (hs_in) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got != 5) begin failures++; $display("FAIL b2b_result_count got=%0d exp=5", got); end
    checks++; if (last - first != 4) begin failures++; $display("FAIL b2b_full_rate span got=%0d exp=4", last - first); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_eq[k] !== exp_eq[k] || got_slt[k] !== exp_slt[k] || got_ult[k] !== exp_ult[k] || got_tag[k] !== 4'(k + 4))
        begin
          failures++;
          $display("FAIL b2b_result mode=%0d got eq=%h slt=%h ult=%h tag=%h exp eq=%h slt=%h ult=%h tag=%h",
                   modes[k], got_eq[k], got_slt[k], got_ult[k], got_tag[k], exp_eq[k], exp_slt[k], exp_ult[k], 4'(k + 4));
        end
    end
  endtask

  task automatic test_reset_flush();
    int stale;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 64'h1; in_b = 64'h1; in_mode = 2'd3;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_tag = 4'(10 + c);
      @(negedge clk);
    end
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_prefill got in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid); end
    rst_n = 1'b0; in_valid = 1'b1; in_tag = 4'h9;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_eq !== 8'h00 || out_slt !== 8'h00 || out_ult !== 8'h00) begin failures++; $display("FAIL flush_masks got eq=%h slt=%h ult=%h exp 00", out_eq, out_slt, out_ult); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL flush_tag got=%h exp=0", out_tag); end
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL flush_stale_results got=%0d exp=0", stale); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_width();
    test_half_width();
    test_byte_lanes();
    test_stall();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
